// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start/a/b; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b (mod 2**WIDTH) over WIDTH cycles.
// One difference/borrow slice per cycle with a registered borrow, IDLE/SHIFT/DONE control.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic             busy_c, done_c, load;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic             br, d_bit, br_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  // Single-bit full-subtractor difference output.
  function automatic logic diff_bit(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Borrow out of one slice: x - y - bi goes negative.
  function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign d_bit    = diff_bit(a_sh[0], b_sh[0], br);
  assign br_next  = borrow_bit(a_sh[0], b_sh[0], br);
  assign res_next = {d_bit, res_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status decode; a new operation may load from IDLE or DONE.
  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shift registers, partial result, borrow and slice counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      count  <= '0;
    end else if (load) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      br     <= 1'b0;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      br     <= br_next;
      count  <= count + 1'b1;
    end
  end

  // Result registers: captured only on the final slice, held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (state == SHIFT && count == LAST) begin
      diff_q <= res_next;
      bout_q <= br_next;
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8) with a result scoreboard.
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int BOUND = 40;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [W:0] sb_q[$];   // {diff, bout}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected value from the arithmetic definition, independent of the slice logic.
  task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] d;
    logic         bo;
    d  = ta - tb_v;
    bo = (ta < tb_v);
    sb_q.push_back({d, bo});
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_diff"}, 32'(bus.diff), 32'(e[W:1]));
      check({tag, "_bout"}, 32'(bus.bout), 32'(e[0]));
    end
  endtask

  // One complete operation; optionally disturbs start/a/b while the operation is busy.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input bit disturb);
    int busy_cnt;
    int waited;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    push_exp(ta, tb_v);
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 0;
    waited    = 0;
    while (bus.done !== 1'b1 && waited < BOUND) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (disturb && waited == 2) begin
        bus.start = 1'b1;
        bus.a     = ~ta;
        bus.b     = ta;
      end
      if (disturb && waited == 3) bus.start = 1'b0;
      waited++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(waited < BOUND), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int gap;
    logic [W-1:0] held_diff;
    bit saw_done;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;

    // Basic operations, including borrow and wrap cases.
    do_op("t1_05_03", 8'h05, 8'h03, 1'b0);
    do_op("t2_03_05", 8'h03, 8'h05, 1'b0);
    do_op("t2_00_01", 8'h00, 8'h01, 1'b0);
    do_op("t2_ff_ff", 8'hFF, 8'hFF, 1'b0);

    // All LSB combinations with upper bits zero.
    do_op("t3_0_0", 8'h00, 8'h00, 1'b0);
    do_op("t3_0_1", 8'h00, 8'h01, 1'b0);
    do_op("t3_1_0", 8'h01, 8'h00, 1'b0);
    do_op("t3_1_1", 8'h01, 8'h01, 1'b0);

    // start re-pulsed and operands changed while busy.
    do_op("t4_ignore", 8'h5A, 8'h3C, 1'b1);

    // start held high through DONE: back-to-back operations.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h9C;
    bus.b     = 8'h21;
    push_exp(8'h9C, 8'h21);
    @(negedge clk);
    bus.a = 8'h10;
    bus.b = 8'h20;
    push_exp(8'h10, 8'h20);
    gap = 0;
    while (bus.done !== 1'b1 && gap < BOUND) begin
      gap++;
      @(negedge clk);
    end
    check("t5_first_done_seen", 32'(gap < BOUND), 32'd1);
    check_result("t5_first");
    held_diff = bus.diff;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) begin
        bus.start = 1'b0;
        check("t5_restart_busy", 32'(bus.busy), 32'd1);
      end
      if (gap == 4) check("t5_diff_hold", 32'(bus.diff), 32'(held_diff));
    end while (bus.done !== 1'b1 && gap < BOUND);
    check("t5_done_period", 32'(gap), 32'(W + 1));
    check_result("t5_second");
    @(negedge clk);
    check("t5_done_pulse", 32'(bus.done), 32'd0);

    // Reset during SHIFT aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    check("t6_rst_diff", 32'(bus.diff), 32'd0);
    check("t6_rst_bout", 32'(bus.bout), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    check("t6_no_done_after_abort", 32'(saw_done), 32'd0);
    do_op("t6_80_01", 8'h80, 8'h01, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
